regfile_arbiter: RTL and testbench

Sequencing front-end for the 64-bit, 32-entry register file (synchronous 1-cycle read, write on clock edge). It clears every register after reset, shares the single read-port pair between two read clients with round-robin arbitration, and accepts a writeback stream. It hides two register-file quirks from clients: x0 reads as zero, and a read sees a write issued in the same cycle to the same address.

---
 rtl/regfile_pkg.sv | 19 +
 rtl/rr_arb2.sv | 30 +++
 rtl/regfile_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_arbiter.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared sizes and types for the register-file sequencing front end.
// Imported by the arbiter and the top-level sequencer.
package regfile_pkg;

    localparam int DATA_W_DEF = 64;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 32;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    typedef enum logic {
        CLI_A,
        CLI_B
    } cli_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-request round-robin arbiter.
// The pointer names the client that wins the next tie.
module rr_arb2
    import regfile_pkg::*;
(
    input  logic clock,
    input  logic reset_n,
    input  logic i_req_a,
    input  logic i_req_b,
    output logic o_gnt_a,
    output logic o_gnt_b
);

    cli_t r_ptr;

    assign o_gnt_a = i_req_a && (!i_req_b || r_ptr == CLI_A);
    assign o_gnt_b = i_req_b && (!i_req_a || r_ptr == CLI_B);

    // The client just served loses the next tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_ptr <= CLI_A;
        end else if (o_gnt_a) begin
            r_ptr <= CLI_B;
        end else if (o_gnt_b) begin
            r_ptr <= CLI_A;
        end
    end

endmodule

// File: rtl/regfile_arbiter.sv
// Register-file front end: clears all registers after reset, then shares
// the read-port pair between two clients and accepts a writeback stream.
module regfile_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic [ADDR_W-1:0] a_rs1,
    input  logic [ADDR_W-1:0] a_rs2,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_rs1,
    input  logic [ADDR_W-1:0] b_rs2,
    output logic              a_resp_valid,
    output logic [DATA_W-1:0] a_rd1,
    output logic [DATA_W-1:0] a_rd2,
    output logic              b_resp_valid,
    output logic [DATA_W-1:0] b_rd1,
    output logic [DATA_W-1:0] b_rd2,
    input  logic              w_valid,
    output logic              w_ready,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_data,
    output logic              rf_read,
    output logic              rf_write,
    output logic [ADDR_W-1:0] rf_rs1,
    output logic [ADDR_W-1:0] rf_rs2,
    output logic [ADDR_W-1:0] rf_wr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rd1,
    input  logic [DATA_W-1:0] rf_rd2,
    output logic              init_busy
);

    state_t            r_state;
    logic [ADDR_W-1:0] r_cnt;

    logic              r_resp;
    cli_t              r_owner;
    logic              r_zero1;
    logic              r_zero2;
    logic              r_fwd1;
    logic              r_fwd2;
    logic [DATA_W-1:0] r_fdata1;
    logic [DATA_W-1:0] r_fdata2;

    logic              w_run;
    logic              w_gnt_a;
    logic              w_gnt_b;
    logic              w_gnt;
    logic              w_wr_act;
    logic [ADDR_W-1:0] w_rs1;
    logic [ADDR_W-1:0] w_rs2;
    logic              w_fwd1;
    logic              w_fwd2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;

    assign w_run     = (r_state == RUN);
    assign init_busy = (r_state == INIT);
    assign w_ready   = w_run;

    rr_arb2 u_arb (
        .clock   (clock),
        .reset_n (reset_n),
        .i_req_a (w_run && a_valid),
        .i_req_b (w_run && b_valid),
        .o_gnt_a (w_gnt_a),
        .o_gnt_b (w_gnt_b)
    );

    assign a_ready  = w_gnt_a;
    assign b_ready  = w_gnt_b;
    assign w_gnt    = w_gnt_a || w_gnt_b;
    assign w_wr_act = w_run && w_valid;

    assign w_rs1 = w_gnt_a ? a_rs1 : (w_gnt_b ? b_rs1 : '0);
    assign w_rs2 = w_gnt_a ? a_rs2 : (w_gnt_b ? b_rs2 : '0);

    assign rf_read = w_gnt;
    assign rf_rs1  = w_rs1;
    assign rf_rs2  = w_rs2;

    // The register file returns the pre-write value on a same-cycle hit.
    assign w_fwd1 = w_wr_act && (w_addr != '0) && (w_rs1 == w_addr);
    assign w_fwd2 = w_wr_act && (w_addr != '0) && (w_rs2 == w_addr);

    always_comb begin
        rf_write = 1'b0;
        rf_wr    = '0;
        rf_wdata = '0;
        if (!w_run) begin
            rf_write = 1'b1;
            rf_wr    = r_cnt;
        end else if (w_wr_act) begin
            rf_write = (w_addr != '0);
            rf_wr    = w_addr;
            rf_wdata = w_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= INIT;
            r_cnt   <= '0;
        end else if (r_state == INIT) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == ADDR_W'(NUM_REGS - 1)) begin
                r_state <= RUN;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_resp   <= 1'b0;
            r_owner  <= CLI_A;
            r_zero1  <= 1'b0;
            r_zero2  <= 1'b0;
            r_fwd1   <= 1'b0;
            r_fwd2   <= 1'b0;
            r_fdata1 <= '0;
            r_fdata2 <= '0;
        end else begin
            r_resp <= w_gnt;
            if (w_gnt) begin
                r_owner  <= w_gnt_b ? CLI_B : CLI_A;
                r_zero1  <= (w_rs1 == '0);
                r_zero2  <= (w_rs2 == '0);
                r_fwd1   <= w_fwd1;
                r_fwd2   <= w_fwd2;
                r_fdata1 <= w_fwd1 ? w_data : '0;
                r_fdata2 <= w_fwd2 ? w_data : '0;
            end
        end
    end

    assign w_rd1 = r_zero1 ? '0 : (r_fwd1 ? r_fdata1 : rf_rd1);
    assign w_rd2 = r_zero2 ? '0 : (r_fwd2 ? r_fdata2 : rf_rd2);

    assign a_resp_valid = r_resp && (r_owner == CLI_A);
    assign b_resp_valid = r_resp && (r_owner == CLI_B);

    assign a_rd1 = a_resp_valid ? w_rd1 : '0;
    assign a_rd2 = a_resp_valid ? w_rd2 : '0;
    assign b_rd1 = b_resp_valid ? w_rd1 : '0;
    assign b_rd2 = b_resp_valid ? w_rd2 : '0;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Directed bench for regfile_arbiter with a behavioural register file
// whose uncleared entries and x0 read back as non-zero junk.
module tb_regfile_arbiter;

    localparam int DW = 64;
    localparam int AW = 5;

    localparam logic [DW-1:0] X5  = 64'h1122334455667788;
    localparam logic [DW-1:0] X7A = 64'h00000000DEADBEEF;
    localparam logic [DW-1:0] X7B = 64'h0000000000001234;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          a_valid, b_valid, w_valid;
    logic          a_ready, b_ready, w_ready;
    logic [AW-1:0] a_rs1, a_rs2, b_rs1, b_rs2, w_addr;
    logic [DW-1:0] w_data;
    logic          a_resp_valid, b_resp_valid;
    logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic          rf_read, rf_write;
    logic [AW-1:0] rf_rs1, rf_rs2, rf_wr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rd1 = '0;
    logic [DW-1:0] rf_rd2 = '0;
    logic          init_busy;

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mem [32];
    logic [31:0]   clean = '0;

    always #5 clock = ~clock;

    // Register file model: x0 and never-written entries return junk.
    always @(posedge clock) begin
        if (rf_write) begin
            mem[rf_wr]   <= rf_wdata;
            clean[rf_wr] <= 1'b1;
        end
        if (rf_read) begin
            rf_rd1 <= (rf_rs1 != 0 && clean[rf_rs1]) ? mem[rf_rs1]
                      : {32'hBADBAD00, 27'd0, rf_rs1};
            rf_rd2 <= (rf_rs2 != 0 && clean[rf_rs2]) ? mem[rf_rs2]
                      : {32'hBADBAD00, 27'd0, rf_rs2};
        end
    end

    regfile_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .a_valid      (a_valid),
        .a_ready      (a_ready),
        .a_rs1        (a_rs1),
        .a_rs2        (a_rs2),
        .b_valid      (b_valid),
        .b_ready      (b_ready),
        .b_rs1        (b_rs1),
        .b_rs2        (b_rs2),
        .a_resp_valid (a_resp_valid),
        .a_rd1        (a_rd1),
        .a_rd2        (a_rd2),
        .b_resp_valid (b_resp_valid),
        .b_rd1        (b_rd1),
        .b_rd2        (b_rd2),
        .w_valid      (w_valid),
        .w_ready      (w_ready),
        .w_addr       (w_addr),
        .w_data       (w_data),
        .rf_read      (rf_read),
        .rf_write     (rf_write),
        .rf_rs1       (rf_rs1),
        .rf_rs2       (rf_rs2),
        .rf_wr        (rf_wr),
        .rf_wdata     (rf_wdata),
        .rf_rd1       (rf_rd1),
        .rf_rd2       (rf_rd2),
        .init_busy    (init_busy)
    );

    task automatic idle();
        a_valid = 0; b_valid = 0; w_valid = 0;
        a_rs1 = 0; a_rs2 = 0; b_rs1 = 0; b_rs2 = 0;
        w_addr = 0; w_data = 0;
    endtask

    task automatic next_cycle();
        @(negedge clock);
        #1;
    endtask

    task automatic test_reset();
        idle();
        reset_n = 0;
        a_valid = 1;
        b_valid = 1;
        next_cycle();
        tests++; if (init_busy !== 1'b1) begin fails++; $display("FAIL rst_init_busy got %b want 1", init_busy); end
        tests++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin fails++; $display("FAIL rst_ready got %b%b want 00", a_ready, b_ready); end
        tests++; if (w_ready !== 1'b0) begin fails++; $display("FAIL rst_w_ready got %b want 0", w_ready); end
        tests++; if (rf_read !== 1'b0) begin fails++; $display("FAIL rst_rf_read got %b want 0", rf_read); end
        tests++; if (rf_write !== 1'b1 || rf_wr !== 5'd0 || rf_wdata !== 64'd0) begin fails++; $display("FAIL rst_rf_write got %b/%0d/%h want 1/0/0", rf_write, rf_wr, rf_wdata); end
        tests++; if (a_resp_valid !== 1'b0 || b_resp_valid !== 1'b0) begin fails++; $display("FAIL rst_resp got %b%b want 00", a_resp_valid, b_resp_valid); end
        tests++; if (a_rd1 !== 64'd0 || b_rd2 !== 64'd0) begin fails++; $display("FAIL rst_rd got %h/%h want 0/0", a_rd1, b_rd2); end
        reset_n = 1;
    endtask

    task automatic test_init();
        for (int i = 0; i < 32; i++) begin
            tests++; if (init_busy !== 1'b1 || a_ready !== 1'b0) begin fails++; $display("FAIL init_busy_%0d got %b/%b want 1/0", i, init_busy, a_ready); end
            tests++; if (rf_write !== 1'b1 || rf_wr !== 5'(i) || rf_wdata !== 64'd0) begin fails++; $display("FAIL init_wr_%0d got %b/%0d/%h want 1/%0d/0", i, rf_write, rf_wr, rf_wdata, i); end
            next_cycle();
        end
        tests++; if (init_busy !== 1'b0) begin fails++; $display("FAIL init_done got %b want 0", init_busy); end
        tests++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin fails++; $display("FAIL first_grant got %b%b want 10", a_ready, b_ready); end
        idle();
        next_cycle();
    endtask

    task automatic test_read_zero();
        for (int k = 0; k <= 16; k++) begin
            if (k < 16) begin
                a_valid = 1;
                a_rs1 = 5'(2 * k);
                a_rs2 = 5'(2 * k + 1);
            end else begin
                a_valid = 0;
            end
            #1;
            if (k < 16) begin
                tests++; if (a_ready !== 1'b1 || rf_read !== 1'b1 || rf_rs1 !== 5'(2 * k)) begin fails++; $display("FAIL zrd_req_%0d got %b/%b/%0d want 1/1/%0d", k, a_ready, rf_read, rf_rs1, 2 * k); end
            end
            if (k > 0) begin
                tests++; if (a_resp_valid !== 1'b1 || a_rd1 !== 64'd0 || a_rd2 !== 64'd0) begin fails++; $display("FAIL zrd_resp_%0d got %b/%h/%h want 1/0/0", k - 1, a_resp_valid, a_rd1, a_rd2); end
            end
            next_cycle();
        end
        idle();
    endtask

    task automatic test_write_read();
        w_valid = 1; w_addr = 5; w_data = X5;
        #1;
        tests++; if (rf_write !== 1'b1 || rf_wr !== 5'd5 || rf_wdata !== X5 || w_ready !== 1'b1) begin fails++; $display("FAIL wr_x5 got %b/%0d/%h/%b want 1/5/%h/1", rf_write, rf_wr, rf_wdata, w_ready, X5); end
        tests++; if (a_resp_valid !== 1'b0) begin fails++; $display("FAIL wr_no_resp got %b want 0", a_resp_valid); end
        next_cycle();
        idle(); a_valid = 1; a_rs1 = 5; a_rs2 = 0;
        #1;
        tests++; if (a_ready !== 1'b1 || rf_read !== 1'b1 || rf_rs1 !== 5'd5) begin fails++; $display("FAIL rd_x5_req got %b/%b/%0d want 1/1/5", a_ready, rf_read, rf_rs1); end
        tests++; if (rf_write !== 1'b0 || rf_wr !== 5'd0 || rf_wdata !== 64'd0) begin fails++; $display("FAIL no_write got %b/%0d/%h want 0/0/0", rf_write, rf_wr, rf_wdata); end
        next_cycle();
        idle();
        #1;
        tests++; if (a_resp_valid !== 1'b1 || b_resp_valid !== 1'b0) begin fails++; $display("FAIL rd_x5_valid got %b%b want 10", a_resp_valid, b_resp_valid); end
        tests++; if (a_rd1 !== X5 || a_rd2 !== 64'd0) begin fails++; $display("FAIL rd_x5_data got %h/%h want %h/0", a_rd1, a_rd2, X5); end
        tests++; if (rf_read !== 1'b0 || rf_rs1 !== 5'd0) begin fails++; $display("FAIL idle_rf_read got %b/%0d want 0/0", rf_read, rf_rs1); end
        next_cycle();
        tests++; if (a_resp_valid !== 1'b0) begin fails++; $display("FAIL resp_one_cycle got %b want 0", a_resp_valid); end
    endtask

    task automatic test_forward();
        idle();
        w_valid = 1; w_addr = 7; w_data = X7A;
        a_valid = 1; a_rs1 = 7; a_rs2 = 7;
        #1;
        tests++; if (a_ready !== 1'b1 || rf_write !== 1'b1) begin fails++; $display("FAIL fwd_req got %b/%b want 1/1", a_ready, rf_write); end
        next_cycle();
        idle(); w_valid = 1; w_addr = 7; w_data = X7B;
        #1;
        tests++; if (a_resp_valid !== 1'b1 || a_rd1 !== X7A || a_rd2 !== X7A) begin fails++; $display("FAIL fwd_data got %b/%h/%h want 1/%h/%h", a_resp_valid, a_rd1, a_rd2, X7A, X7A); end
        next_cycle();
        idle(); a_valid = 1; a_rs1 = 7; a_rs2 = 5;
        next_cycle();
        idle();
        #1;
        tests++; if (a_resp_valid !== 1'b1 || a_rd1 !== X7B || a_rd2 !== X5) begin fails++; $display("FAIL later_write got %b/%h/%h want 1/%h/%h", a_resp_valid, a_rd1, a_rd2, X7B, X5); end
        next_cycle();
    endtask

    task automatic test_x0();
        idle();
        w_valid = 1; w_addr = 0; w_data = 64'hFFFF;
        a_valid = 1; a_rs1 = 0; a_rs2 = 0;
        #1;
        tests++; if (rf_write !== 1'b0 || w_ready !== 1'b1 || a_ready !== 1'b1) begin fails++; $display("FAIL x0_write got %b/%b/%b want 0/1/1", rf_write, w_ready, a_ready); end
        next_cycle();
        idle();
        #1;
        tests++; if (a_resp_valid !== 1'b1 || a_rd1 !== 64'd0 || a_rd2 !== 64'd0) begin fails++; $display("FAIL x0_read got %b/%h/%h want 1/0/0", a_resp_valid, a_rd1, a_rd2); end
        next_cycle();
    endtask

    task automatic test_round_robin();
        bit exp_a;
        bit prev_a;
        idle();
        b_valid = 1; b_rs1 = 5; b_rs2 = 7;
        #1;
        tests++; if (b_ready !== 1'b1 || a_ready !== 1'b0) begin fails++; $display("FAIL b_only_gnt got %b%b want 01", a_ready, b_ready); end
        next_cycle();
        idle();
        #1;
        tests++; if (b_resp_valid !== 1'b1 || a_resp_valid !== 1'b0) begin fails++; $display("FAIL b_only_valid got %b%b want 01", a_resp_valid, b_resp_valid); end
        tests++; if (b_rd1 !== X5 || b_rd2 !== X7B || a_rd1 !== 64'd0) begin fails++; $display("FAIL b_only_data got %h/%h/%h want %h/%h/0", b_rd1, b_rd2, a_rd1, X5, X7B); end
        next_cycle();
        for (int k = 0; k <= 4; k++) begin
            if (k < 4) begin
                a_valid = 1; a_rs1 = 5; a_rs2 = 7;
                b_valid = 1; b_rs1 = 7; b_rs2 = 5;
            end else begin
                idle();
            end
            #1;
            if (k < 4) begin
                exp_a = (k % 2 == 0);
                tests++; if (a_ready !== exp_a || b_ready !== !exp_a) begin fails++; $display("FAIL rr_gnt_%0d got %b%b want %b%b", k, a_ready, b_ready, exp_a, !exp_a); end
            end
            if (k > 0) begin
                prev_a = ((k - 1) % 2 == 0);
                tests++; if (a_resp_valid !== prev_a || b_resp_valid !== !prev_a) begin fails++; $display("FAIL rr_valid_%0d got %b%b want %b%b", k - 1, a_resp_valid, b_resp_valid, prev_a, !prev_a); end
                if (prev_a) begin
                    tests++; if (a_rd1 !== X5 || a_rd2 !== X7B) begin fails++; $display("FAIL rr_a_data_%0d got %h/%h want %h/%h", k - 1, a_rd1, a_rd2, X5, X7B); end
                end else begin
                    tests++; if (b_rd1 !== X7B || b_rd2 !== X5) begin fails++; $display("FAIL rr_b_data_%0d got %h/%h want %h/%h", k - 1, b_rd1, b_rd2, X7B, X5); end
                end
            end
            next_cycle();
        end
    endtask

    task automatic test_reset_midop();
        idle();
        a_valid = 1; a_rs1 = 5;
        #1;
        tests++; if (a_ready !== 1'b1) begin fails++; $display("FAIL mid_gnt got %b want 1", a_ready); end
        @(posedge clock);
        #1;
        reset_n = 0;
        idle();
        #1;
        tests++; if (a_resp_valid !== 1'b0 || a_rd1 !== 64'd0) begin fails++; $display("FAIL mid_drop got %b/%h want 0/0", a_resp_valid, a_rd1); end
        tests++; if (init_busy !== 1'b1 || rf_wr !== 5'd0) begin fails++; $display("FAIL mid_reinit got %b/%0d want 1/0", init_busy, rf_wr); end
        next_cycle();
        reset_n = 1;
        for (int i = 0; i < 32; i++) begin
            tests++; if (init_busy !== 1'b1 || rf_wr !== 5'(i) || a_resp_valid !== 1'b0) begin fails++; $display("FAIL reinit_%0d got %b/%0d/%b want 1/%0d/0", i, init_busy, rf_wr, a_resp_valid, i); end
            next_cycle();
        end
        tests++; if (init_busy !== 1'b0) begin fails++; $display("FAIL reinit_done got %b want 0", init_busy); end
        a_valid = 1; a_rs1 = 5; a_rs2 = 7;
        next_cycle();
        idle();
        #1;
        tests++; if (a_resp_valid !== 1'b1 || a_rd1 !== 64'd0 || a_rd2 !== 64'd0) begin fails++; $display("FAIL reinit_clear got %b/%h/%h want 1/0/0", a_resp_valid, a_rd1, a_rd2); end
        next_cycle();
    endtask

    initial begin
        test_reset();
        test_init();
        test_read_zero();
        test_write_read();
        test_forward();
        test_x0();
        test_round_robin();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after %0d tests", tests);
        $fatal(1, "timeout");
    end

endmodule
